timer_core_param: RTL and testbench

Parametrised two-mode timer core: a count-up stopwatch (mode A) and a preset count-down timer (mode B). Generalises the existing fixed 8-bit, 99.99 / 1–8 minute timer. Radix, limits and preset width are parameters, counting is driven by an external tick strobe rather than a divided clock, and mode B counts genuinely downward with no reversal stage. It sits between the tick/debounce front end and the binary-to-display conversion path.

---
 rtl/timer_core_param_pkg.sv | 22 ++
 rtl/timer_core_param_if.sv | 29 ++
 rtl/timer_core_param_mod_counter.sv | 48 ++++
 rtl/timer_core_param.sv | 180 ++++++++++++++++++
 tb/tb_timer_core_param.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_core_param_pkg.sv
// Shared types and default radix constants for the two-mode timer core.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  localparam int DEF_DIGIT_W   = 8;
  localparam int DEF_LSB_MOD_A = 100;
  localparam int DEF_LSB_MOD_B = 60;
  localparam int DEF_MSB_MAX_A = 99;
  localparam int DEF_PRESET_W  = 3;

endpackage

// File: rtl/timer_core_param_if.sv
// Control/display bundle between the tick front end, the timer core and the
// display path. The timer core takes the slave side.
interface timer_core_param_if #(
  parameter int DIGIT_W  = 8,
  parameter int PRESET_W = 3
);
  logic                tick;
  logic                start_stop;
  logic                mode_sel;
  logic [PRESET_W-1:0] preset;
  logic                lap;
  logic [DIGIT_W-1:0]  lsb_out;
  logic [DIGIT_W-1:0]  msb_out;
  logic [DIGIT_W-1:0]  lap_lsb;
  logic [DIGIT_W-1:0]  lap_msb;
  logic                lap_valid;
  logic                running;
  logic                done;

  modport master (
    output tick, start_stop, mode_sel, preset, lap,
    input  lsb_out, msb_out, lap_lsb, lap_msb, lap_valid, running, done
  );

  modport slave (
    input  tick, start_stop, mode_sel, preset, lap,
    output lsb_out, msb_out, lap_lsb, lap_msb, lap_valid, running, done
  );
endinterface

// File: rtl/timer_core_param_mod_counter.sv
// One modular counter field: up (wrap max->0) or down (borrow 0->max),
// synchronous load with priority over enable. carry_out flags wrap/borrow.
module mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             carry_out
);

  // Next-value selection; exposed so the parent can detect the terminal value
  // in the same cycle the counter reaches it.
  always_comb begin
    count_next = count;
    carry_out  = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      if (up) begin
        if (count == max_val) begin
          count_next = '0;
          carry_out  = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          count_next = max_val;
          carry_out  = 1'b1;
        end else begin
          count_next = count - 1'b1;
        end
      end
    end
  end

  // Field register.
  always_ff @(posedge clk) begin
    count <= count_next;
  end

endmodule

// File: rtl/timer_core_param.sv
// Two-mode timer core: count-up stopwatch (mode A) and preset count-down
// timer (mode B), advanced by an external tick strobe.
// Optional split-time capture is built when TIMER_LAP_EN is defined.
module timer_core_param
  import timer_pkg::*;
#(
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter int LSB_MOD_A = DEF_LSB_MOD_A,
  parameter int LSB_MOD_B = DEF_LSB_MOD_B,
  parameter int MSB_MAX_A = DEF_MSB_MAX_A,
  parameter int PRESET_W  = DEF_PRESET_W
) (
  input logic               clk,
  input logic               rst_n,
  timer_core_param_if.slave bus
);

  localparam logic [DIGIT_W-1:0] LSB_MAX_A = DIGIT_W'(LSB_MOD_A - 1);
  localparam logic [DIGIT_W-1:0] LSB_MAX_B = DIGIT_W'(LSB_MOD_B - 1);
  localparam logic [DIGIT_W-1:0] MSB_TERM  = DIGIT_W'(MSB_MAX_A);

  state_e              state;
  mode_e               mode_q;
  logic [PRESET_W-1:0] preset_q;
  logic                running_q;
  logic                done_q;

  logic                cfg_chg;
  logic                load;
  logic                cnt_en;
  logic                count_up;
  logic                term_hit;
  logic [DIGIT_W-1:0]  lsb_init;
  logic [DIGIT_W-1:0]  msb_init;
  logic [DIGIT_W-1:0]  lsb_max;
  logic [DIGIT_W-1:0]  msb_max;
  logic [DIGIT_W-1:0]  lsb_cnt;
  logic [DIGIT_W-1:0]  msb_cnt;
  logic [DIGIT_W-1:0]  lsb_next;
  logic [DIGIT_W-1:0]  msb_next;
  logic                lsb_carry;
  logic                msb_carry;

  // Configuration tracking, reload and count-enable qualification.
  always_comb begin
    cfg_chg  = (mode_e'(bus.mode_sel) != mode_q) || (bus.preset != preset_q);
    // Reload always targets the live inputs: on reset/config change they are
    // the new configuration, on restart from DONE they equal the copies.
    lsb_init = '0;
    msb_init = bus.mode_sel ? (DIGIT_W'(bus.preset) + DIGIT_W'(1)) : '0;
    load     = !rst_n || cfg_chg || (state == DONE && bus.start_stop);
    cnt_en   = rst_n && !cfg_chg && (state == RUN) && bus.tick;
    count_up = (mode_q == MODE_UP);
    lsb_max  = count_up ? LSB_MAX_A : LSB_MAX_B;
    msb_max  = count_up ? MSB_TERM : '1;
  end

  mod_counter #(.WIDTH(DIGIT_W)) u_lsb (
    .clk       (clk),
    .load      (load),
    .load_val  (lsb_init),
    .en        (cnt_en),
    .up        (count_up),
    .max_val   (lsb_max),
    .count     (lsb_cnt),
    .count_next(lsb_next),
    .carry_out (lsb_carry)
  );

  mod_counter #(.WIDTH(DIGIT_W)) u_msb (
    .clk       (clk),
    .load      (load),
    .load_val  (msb_init),
    .en        (cnt_en && lsb_carry),
    .up        (count_up),
    .max_val   (msb_max),
    .count     (msb_cnt),
    .count_next(msb_next),
    .carry_out (msb_carry)
  );

  // Terminal is judged on the post-tick value so done rises with it; an MSB
  // wrap/borrow can only mean the terminal was crossed, so it also stops.
  always_comb begin
    term_hit = 1'b0;
    if (cnt_en) begin
      if (count_up) begin
        term_hit = (lsb_next == LSB_MAX_A) && (msb_next == MSB_TERM);
      end else begin
        term_hit = (lsb_next == '0) && (msb_next == '0);
      end
      term_hit = term_hit || msb_carry;
    end
  end

  // Run-control FSM with registered running/done; reset and config change
  // share one path because their effect on this state is identical.
  always_ff @(posedge clk) begin
    if (!rst_n || cfg_chg) begin
      state     <= IDLE;
      mode_q    <= mode_e'(bus.mode_sel);
      preset_q  <= bus.preset;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (term_hit) begin
            state     <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (bus.start_stop) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start_stop) begin
            state     <= RUN;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lsb_out = lsb_cnt;
  assign bus.msb_out = msb_cnt;
  assign bus.running = running_q;
  assign bus.done    = done_q;

`ifdef TIMER_LAP_EN
  logic [DIGIT_W-1:0] lap_lsb_q;
  logic [DIGIT_W-1:0] lap_msb_q;
  logic               lap_valid_q;

  // Split capture of the pre-edge display; a config change only drops the
  // valid flag, the held fields are cleared by reset alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_lsb_q   <= '0;
      lap_msb_q   <= '0;
      lap_valid_q <= 1'b0;
    end else if (cfg_chg) begin
      lap_valid_q <= 1'b0;
    end else if (bus.lap && (state == RUN || state == PAUSE)) begin
      lap_lsb_q   <= lsb_cnt;
      lap_msb_q   <= msb_cnt;
      lap_valid_q <= 1'b1;
    end
  end

  assign bus.lap_lsb   = lap_lsb_q;
  assign bus.lap_msb   = lap_msb_q;
  assign bus.lap_valid = lap_valid_q;
`else
  assign bus.lap_lsb   = '0;
  assign bus.lap_msb   = '0;
  assign bus.lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timer_core_param.sv
// Self-checking bench for timer_core_param: directed scenarios plus a
// randomized run against a value-level reference model (elapsed/remaining
// units held as a single integer).
module tb_timer_core_param;
  import timer_pkg::*;

  localparam int DW     = 8;
  localparam int PW     = 3;
  localparam int MODA   = 100;
  localparam int MODB   = 60;
  localparam int MAXA   = 99;
  localparam int TERM_A = MAXA * MODA + (MODA - 1);
`ifdef TIMER_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_PAUSE = 2;
  localparam int P_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  timer_core_param_if #(.DIGIT_W(DW), .PRESET_W(PW)) bus ();

  timer_core_param #(
    .DIGIT_W  (DW),
    .LSB_MOD_A(MODA),
    .LSB_MOD_B(MODB),
    .MSB_MAX_A(MAXA),
    .PRESET_W (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit cfg_mode;
  int cfg_preset;

  // Reference model: total = elapsed units (mode A) or remaining units (mode B).
  bit m_mode;
  int m_preset = -1;
  int m_total;
  int m_phase;
  int m_lap_lsb;
  int m_lap_msb;
  bit m_lap_valid;

  function automatic int init_total(bit md, int pr);
    return md ? (pr + 1) * MODB : 0;
  endfunction

  function automatic int disp_lsb();
    return m_mode ? (m_total % MODB) : (m_total % MODA);
  endfunction

  function automatic int disp_msb();
    return m_mode ? (m_total / MODB) : (m_total / MODA);
  endfunction

  function automatic logic [2*DW+1:0] pack(bit r, bit d, int m, int l);
    return {r, d, DW'(m), DW'(l)};
  endfunction

  function automatic logic [2*DW:0] pack_lap(bit v, int m, int l);
    return {v, DW'(m), DW'(l)};
  endfunction

  function automatic void model_update(bit r, bit tk, bit ss, bit lp);
    int term;
    if (!r || cfg_mode != m_mode || cfg_preset != m_preset) begin
      if (!r) begin
        m_lap_lsb = 0;
        m_lap_msb = 0;
      end
      m_mode      = cfg_mode;
      m_preset    = cfg_preset;
      m_total     = init_total(cfg_mode, cfg_preset);
      m_phase     = P_IDLE;
      m_lap_valid = 1'b0;
    end else begin
      if (LAP_EN && lp && (m_phase == P_RUN || m_phase == P_PAUSE)) begin
        m_lap_lsb   = disp_lsb();
        m_lap_msb   = disp_msb();
        m_lap_valid = 1'b1;
      end
      term = m_mode ? 0 : TERM_A;
      case (m_phase)
        P_IDLE:  if (ss) m_phase = P_RUN;
        P_RUN: begin
          if (tk) m_total = m_mode ? m_total - 1 : m_total + 1;
          if (tk && m_total == term) m_phase = P_DONE;
          else if (ss) m_phase = P_PAUSE;
        end
        P_PAUSE: if (ss) m_phase = P_RUN;
        default: begin
          if (ss) begin
            m_total = init_total(m_mode, m_preset);
            m_phase = P_RUN;
          end
        end
      endcase
    end
  endfunction

  // One clock: drive inputs at negedge, advance model at the edge, settle.
  task automatic step(input bit r, input bit tk, input bit ss, input bit lp);
    @(negedge clk);
    rst_n          = r;
    bus.tick       = tk;
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.mode_sel   = cfg_mode;
    bus.preset     = PW'(cfg_preset);
    @(posedge clk);
    model_update(r, tk, ss, lp);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [2*DW+1:0] obs;
    logic [2*DW:0]   lobs;
    cfg_mode = 1'b0; cfg_preset = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1);
    obs  = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    lobs = {bus.lap_valid, bus.lap_msb, bus.lap_lsb};
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) begin
      n_errors++; $display("FAIL reset_a: got %h expected %h", obs, pack(0, 0, 0, 0));
    end
    n_checks++;
    if (lobs !== pack_lap(0, 0, 0)) begin
      n_errors++; $display("FAIL reset_lap: got %h expected %h", lobs, pack_lap(0, 0, 0));
    end
  endtask

  task automatic test_mode_a_wrap();
    logic [2*DW+1:0] obs;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(100);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 1, 0)) begin
      n_errors++; $display("FAIL a_wrap_100: got %h expected %h", obs, pack(1, 0, 1, 0));
    end
    ticks(TERM_A - 101);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 99, 98)) begin
      n_errors++; $display("FAIL a_pre_term: got %h expected %h", obs, pack(1, 0, 99, 98));
    end
    ticks(1);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 1, 99, 99)) begin
      n_errors++; $display("FAIL a_term: got %h expected %h", obs, pack(0, 1, 99, 99));
    end
    ticks(5);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 1, 99, 99)) begin
      n_errors++; $display("FAIL a_hold_done: got %h expected %h", obs, pack(0, 1, 99, 99));
    end
  endtask

  task automatic test_restart();
    logic [2*DW+1:0] obs;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 0, 0)) begin
      n_errors++; $display("FAIL restart_done: got %h expected %h", obs, pack(1, 0, 0, 0));
    end
    ticks(317);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 3, 17)) begin
      n_errors++; $display("FAIL run_317: got %h expected %h", obs, pack(1, 0, 3, 17));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) begin
      n_errors++; $display("FAIL reset_mid_run: got %h expected %h", obs, pack(0, 0, 0, 0));
    end
  endtask

  task automatic test_mode_b();
    logic [2*DW+1:0] obs;
    cfg_mode = 1'b1; cfg_preset = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 0, 2, 0)) begin
      n_errors++; $display("FAIL b_reset: got %h expected %h", obs, pack(0, 0, 2, 0));
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(1);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 1, 59)) begin
      n_errors++; $display("FAIL b_first_tick: got %h expected %h", obs, pack(1, 0, 1, 59));
    end
    ticks(118);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 0, 1)) begin
      n_errors++; $display("FAIL b_pre_term: got %h expected %h", obs, pack(1, 0, 0, 1));
    end
    ticks(2);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 1, 0, 0)) begin
      n_errors++; $display("FAIL b_term: got %h expected %h", obs, pack(0, 1, 0, 0));
    end
  endtask

  task automatic test_same_cycle();
    logic [2*DW+1:0] obs;
    cfg_mode = 1'b0; cfg_preset = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 0, 0, 6)) begin
      n_errors++; $display("FAIL stop_with_tick: got %h expected %h", obs, pack(0, 0, 0, 6));
    end
    step(1'b1, 1'b1, 1'b1, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 0, 6)) begin
      n_errors++; $display("FAIL start_with_tick: got %h expected %h", obs, pack(1, 0, 0, 6));
    end
  endtask

  task automatic test_cfg_change();
    logic [2*DW+1:0] obs;
    cfg_mode = 1'b1; cfg_preset = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(30);
    cfg_preset = 4;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(0, 0, 5, 0)) begin
      n_errors++; $display("FAIL cfg_reload: got %h expected %h", obs, pack(0, 0, 5, 0));
    end
    ticks(3);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(1);
    obs = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    n_checks++;
    if (obs !== pack(1, 0, 4, 59)) begin
      n_errors++; $display("FAIL cfg_resume: got %h expected %h", obs, pack(1, 0, 4, 59));
    end
  endtask

  task automatic test_lap();
    logic [2*DW+1:0] obs;
    logic [2*DW:0]   lobs;
    logic [2*DW:0]   lexp;
    cfg_mode = 1'b0; cfg_preset = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    lobs = {bus.lap_valid, bus.lap_msb, bus.lap_lsb};
    n_checks++;
    if (lobs !== pack_lap(0, 0, 0)) begin
      n_errors++; $display("FAIL lap_in_idle: got %h expected %h", lobs, pack_lap(0, 0, 0));
    end
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(42);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    obs  = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
    lobs = {bus.lap_valid, bus.lap_msb, bus.lap_lsb};
    lexp = LAP_EN ? pack_lap(1, 0, 42) : pack_lap(0, 0, 0);
    n_checks++;
    if (obs !== pack(1, 0, 0, 43)) begin
      n_errors++; $display("FAIL lap_display: got %h expected %h", obs, pack(1, 0, 0, 43));
    end
    n_checks++;
    if (lobs !== lexp) begin
      n_errors++; $display("FAIL lap_capture: got %h expected %h", lobs, lexp);
    end
  endtask

  task automatic test_random();
    logic [2*DW+1:0] obs;
    logic [2*DW+1:0] exp;
    logic [2*DW:0]   lobs;
    logic [2*DW:0]   lexp;
    bit r, tk, ss, lp;
    cfg_mode = 1'b1; cfg_preset = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        cfg_mode   = 1'($urandom_range(0, 1));
        cfg_preset = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
      end
      r  = ($urandom_range(0, 299) != 0);
      tk = ($urandom_range(0, 3) != 0);
      ss = ($urandom_range(0, 24) == 0);
      lp = ($urandom_range(0, 9) == 0);
      step(r, tk, ss, lp);
      obs  = {bus.running, bus.done, bus.msb_out, bus.lsb_out};
      exp  = pack(m_phase == P_RUN, m_phase == P_DONE, disp_msb(), disp_lsb());
      lobs = {bus.lap_valid, bus.lap_msb, bus.lap_lsb};
      lexp = pack_lap(m_lap_valid, m_lap_msb, m_lap_lsb);
      n_checks++;
      if (obs !== exp) begin
        n_errors++; $display("FAIL rand_main cycle %0d: got %h expected %h", i, obs, exp);
      end
      n_checks++;
      if (lobs !== lexp) begin
        n_errors++; $display("FAIL rand_lap cycle %0d: got %h expected %h", i, lobs, lexp);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.tick       = 1'b0;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.mode_sel   = 1'b0;
    bus.preset     = '0;
    cfg_mode       = 1'b0;
    cfg_preset     = 0;
    test_reset();
    test_mode_a_wrap();
    test_restart();
    test_mode_b();
    test_same_cycle();
    test_cfg_change();
    test_lap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
